// File: rtl/intc_ls1u_pkg.sv
// intc_ls1u_pkg: shared constants for the LS1u+ interrupt controller.
//   - register window offsets (daddr[4:0])
//   - maximum source count and CTRL bit positions
//   - src_mask(): mask of implemented request bits for a given source count
package intc_ls1u_pkg;

   localparam int unsigned NSRC_MAX = 32;

   localparam logic [4:0] INTC_PEND0 = 5'h00;
   localparam logic [4:0] INTC_PEND1 = 5'h01;
   localparam logic [4:0] INTC_PEND2 = 5'h02;
   localparam logic [4:0] INTC_PEND3 = 5'h03;
   localparam logic [4:0] INTC_EN0   = 5'h04;
   localparam logic [4:0] INTC_EN1   = 5'h05;
   localparam logic [4:0] INTC_EN2   = 5'h06;
   localparam logic [4:0] INTC_EN3   = 5'h07;
   localparam logic [4:0] INTC_TRIG0 = 5'h08;
   localparam logic [4:0] INTC_TRIG1 = 5'h09;
   localparam logic [4:0] INTC_TRIG2 = 5'h0A;
   localparam logic [4:0] INTC_TRIG3 = 5'h0B;
   localparam logic [4:0] INTC_CTRL  = 5'h0C;
   localparam logic [4:0] INTC_CUR   = 5'h0D;
   localparam logic [4:0] INTC_IVT0  = 5'h0E;
   localparam logic [4:0] INTC_IVT1  = 5'h0F;
   localparam logic [4:0] INTC_IVT2  = 5'h10;
   localparam logic [4:0] INTC_SWI   = 5'h11;

   localparam int unsigned CTRL_GIE = 0;

   // Ones in bit positions [nsrc-1:0], zeros above.
   function automatic logic [31:0] src_mask(input int unsigned nsrc);
      return 32'hFFFF_FFFF >> (NSRC_MAX - nsrc);
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational 32-to-5 priority encoder, lowest index wins.
//   req   in  32  request vector
//   idx   out 5   index of the lowest set bit (0 when no bit set)
//   valid out 1   any bit of req set
module intc_prio_enc
   import intc_ls1u_pkg::*;
(
   input  logic [NSRC_MAX-1:0] req,
   output logic [4:0]          idx,
   output logic                valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < NSRC_MAX; i++) begin
         if (req[i] && !valid) begin
            idx   = 5'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intc_ls1u.sv
// intc_ls1u: memory-mapped priority interrupt controller for the LS1u+ core.
//   clk       in  1     system clock
//   rst       in  1     synchronous reset, active low
//   irq       in  NSRC  request lines, synchronous to clk
//   sel       in  1     register window selected
//   addr      in  5     register offset
//   we        in  1     write strobe
//   wdata     in  8     write data
//   rdata     out 8     read data, combinational, 0 when sel=0
//   int_o     out 1     interrupt request to the CPU
//   intcode_o out 6     winning source index to the CPU (bit 5 always 0)
//   ivt_addr  out 24    vector table base to the CPU
module intc_ls1u
   import intc_ls1u_pkg::*;
#(
   parameter int unsigned NSRC = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq,
   input  logic            sel,
   input  logic [4:0]      addr,
   input  logic            we,
   input  logic [7:0]      wdata,
   output logic [7:0]      rdata,
   output logic            int_o,
   output logic [5:0]      intcode_o,
   output logic [23:0]     ivt_addr
);

   // Bits at NSRC and above are forced to 0 in every stored vector.
   localparam logic [31:0] SRC_MASK = src_mask(NSRC);

   logic [31:0] pend;
   logic [31:0] en;
   logic [31:0] trig;
   logic [31:0] irq_prev;
   logic        gie;
   logic [23:0] ivt;

   logic [31:0] irq_w;
   logic        wr;
   logic [4:0]  lane;
   logic [31:0] set_v;
   logic [31:0] clr_v;
   logic [31:0] swi_v;
   logic [31:0] en_nxt;
   logic [31:0] trig_nxt;
   logic [31:0] act;
   logic [4:0]  win_idx;
   logic        win_valid;

   always_comb begin
      irq_w           = '0;
      irq_w[NSRC-1:0] = irq;
   end

   assign wr   = sel & we;
   assign lane = {addr[1:0], 3'b000};

   // Edge sources fire on a 0->1 transition, level sources while high.
   assign set_v = (trig & irq_w & ~irq_prev) | (~trig & irq_w);

   always_comb begin
      clr_v    = '0;
      swi_v    = '0;
      en_nxt   = en;
      trig_nxt = trig;
      if (wr) begin
         case (addr)
            INTC_PEND0, INTC_PEND1, INTC_PEND2, INTC_PEND3: clr_v[lane +: 8]    = wdata;
            INTC_EN0, INTC_EN1, INTC_EN2, INTC_EN3:         en_nxt[lane +: 8]   = wdata;
            INTC_TRIG0, INTC_TRIG1, INTC_TRIG2, INTC_TRIG3: trig_nxt[lane +: 8] = wdata;
            // Out-of-range indices are dropped by SRC_MASK at the register.
            INTC_SWI:                                       swi_v[wdata[4:0]]   = 1'b1;
            default: ;
         endcase
      end
   end

   assign act = pend & en & {32{gie}};

   intc_prio_enc u_prio_enc (
      .req   (act),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend      <= '0;
         en        <= '0;
         trig      <= '0;
         irq_prev  <= '0;
         gie       <= 1'b0;
         ivt       <= '0;
         int_o     <= 1'b0;
         intcode_o <= '0;
      end else begin
         // A new set wins over a same-cycle clear so no event is lost.
         pend     <= (set_v | swi_v | (pend & ~clr_v)) & SRC_MASK;
         en       <= en_nxt & SRC_MASK;
         trig     <= trig_nxt & SRC_MASK;
         irq_prev <= irq_w;
         if (wr) begin
            case (addr)
               INTC_CTRL: gie          <= wdata[CTRL_GIE];
               INTC_IVT0: ivt[7:0]     <= wdata;
               INTC_IVT1: ivt[15:8]    <= wdata;
               INTC_IVT2: ivt[23:16]   <= wdata;
               default: ;
            endcase
         end
         // Flag and code come from the same registered sample.
         int_o     <= win_valid;
         intcode_o <= {1'b0, win_idx};
      end
   end

   assign ivt_addr = ivt;

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (addr)
            INTC_PEND0, INTC_PEND1, INTC_PEND2, INTC_PEND3: rdata = pend[lane +: 8];
            INTC_EN0, INTC_EN1, INTC_EN2, INTC_EN3:         rdata = en[lane +: 8];
            INTC_TRIG0, INTC_TRIG1, INTC_TRIG2, INTC_TRIG3: rdata = trig[lane +: 8];
            INTC_CTRL: rdata = {7'b0, gie};
            INTC_CUR:  rdata = {int_o, 2'b00, intcode_o[4:0]};
            INTC_IVT0: rdata = ivt[7:0];
            INTC_IVT1: rdata = ivt[15:8];
            INTC_IVT2: rdata = ivt[23:16];
            default:   rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_intc_ls1u.sv
// tb_intc_ls1u: self-checking bench for intc_ls1u (NSRC=32 plus an NSRC=20 copy).
module tb_intc_ls1u;
   import intc_ls1u_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] irq;
   logic        sel;
   logic [4:0]  addr;
   logic        we;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        int_o;
   logic [5:0]  intcode_o;
   logic [23:0] ivt_addr;
   logic [7:0]  rdata20;
   logic        int20;
   logic [5:0]  intcode20;
   logic [23:0] ivt20;

   intc_ls1u #(.NSRC(32)) u_dut (
      .clk(clk), .rst(rst), .irq(irq), .sel(sel), .addr(addr), .we(we),
      .wdata(wdata), .rdata(rdata), .int_o(int_o), .intcode_o(intcode_o),
      .ivt_addr(ivt_addr)
   );

   intc_ls1u #(.NSRC(20)) u_dut20 (
      .clk(clk), .rst(rst), .irq(irq[19:0]), .sel(sel), .addr(addr), .we(we),
      .wdata(wdata), .rdata(rdata20), .int_o(int20), .intcode_o(intcode20),
      .ivt_addr(ivt20)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef enum logic [2:0] {OBS_RD, OBS_RD20, OBS_INT, OBS_CODE, OBS_IVT} obs_e;

   typedef struct {
      string       name;
      obs_e        kind;
      logic [4:0]  addr;
      logic [31:0] exp;
   } sb_t;

   typedef struct {
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   localparam int NV = 16;

   sb_t  sb[$];
   vec_t vecs[NV];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      sel   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      step();
      sel = 1'b0;
      we  = 1'b0;
   endtask

   function automatic void expect_(input string n, input obs_e k, input logic [4:0] a,
                                   input logic [31:0] v);
      sb_t e;
      e.name = n;
      e.kind = k;
      e.addr = a;
      e.exp  = v;
      sb.push_back(e);
   endfunction

   task automatic drain();
      sb_t         e;
      logic [31:0] act;
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         act = '0;
         case (e.kind)
            OBS_RD: begin
               sel = 1'b1; we = 1'b0; addr = e.addr; #1;
               act = {24'b0, rdata};
               sel = 1'b0;
            end
            OBS_RD20: begin
               sel = 1'b1; we = 1'b0; addr = e.addr; #1;
               act = {24'b0, rdata20};
               sel = 1'b0;
            end
            OBS_INT:  act = {31'b0, int_o};
            OBS_CODE: act = {26'b0, intcode_o};
            OBS_IVT:  act = {8'b0, ivt_addr};
            default:  act = '1;
         endcase
         n_cmp++;
         if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s (addr 0x%02h): actual 0x%0h required 0x%0h",
                     e.name, e.addr, act, e.exp);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; irq = '0;

      vecs[0]  = '{INTC_EN0,   8'hA5, 8'hA5};
      vecs[1]  = '{INTC_EN1,   8'h5A, 8'h5A};
      vecs[2]  = '{INTC_EN2,   8'hFF, 8'hFF};
      vecs[3]  = '{INTC_EN3,   8'h81, 8'h81};
      vecs[4]  = '{INTC_TRIG0, 8'h3C, 8'h3C};
      vecs[5]  = '{INTC_TRIG1, 8'hC3, 8'hC3};
      vecs[6]  = '{INTC_TRIG2, 8'h0F, 8'h0F};
      vecs[7]  = '{INTC_TRIG3, 8'hF0, 8'hF0};
      vecs[8]  = '{INTC_CTRL,  8'hFF, 8'h01};
      vecs[9]  = '{INTC_CUR,   8'hFF, 8'h00};
      vecs[10] = '{INTC_IVT0,  8'h12, 8'h12};
      vecs[11] = '{INTC_IVT1,  8'h34, 8'h34};
      vecs[12] = '{INTC_IVT2,  8'h56, 8'h56};
      vecs[13] = '{5'h12,      8'hFF, 8'h00};
      vecs[14] = '{5'h1F,      8'hFF, 8'h00};
      vecs[15] = '{INTC_CTRL,  8'h00, 8'h00};

      step(); step();
      rst = 1'b1;

      // Reset state
      expect_("rst_int", OBS_INT, 5'd0, 32'd0);
      expect_("rst_code", OBS_CODE, 5'd0, 32'd0);
      expect_("rst_ivt", OBS_IVT, 5'd0, 32'd0);
      drain();
      for (int a = 0; a < 32; a++) begin
         expect_("rst_rd", OBS_RD, 5'(a), 32'd0);
         drain();
      end

      // Register read/write table
      for (int i = 0; i < NV; i++) begin
         wr(vecs[i].addr, vecs[i].wdata);
         expect_("tbl_rd", OBS_RD, vecs[i].addr, {24'b0, vecs[i].exp});
         drain();
      end
      expect_("tbl_ivt", OBS_IVT, 5'd0, 32'h563412);
      expect_("tbl_en0_keep", OBS_RD, INTC_EN0, 32'hA5);
      expect_("tbl_en3_keep", OBS_RD, INTC_EN3, 32'h81);
      expect_("tbl_int", OBS_INT, 5'd0, 32'd0);
      drain();

      rst = 1'b0; step(); rst = 1'b1;

      // 1. Edge source latency and acknowledge
      wr(INTC_TRIG0, 8'h01); wr(INTC_EN0, 8'h01); wr(INTC_CTRL, 8'h01);
      irq[0] = 1'b1; step(); irq[0] = 1'b0;
      expect_("t1_pend_n1", OBS_RD, INTC_PEND0, 32'h01);
      expect_("t1_int_n1", OBS_INT, 5'd0, 32'd0);
      drain();
      step();
      expect_("t1_int_n2", OBS_INT, 5'd0, 32'd1);
      expect_("t1_code_n2", OBS_CODE, 5'd0, 32'd0);
      drain();
      wr(INTC_PEND0, 8'h01);
      expect_("t1_int_m1", OBS_INT, 5'd0, 32'd1);
      expect_("t1_pend_m1", OBS_RD, INTC_PEND0, 32'h00);
      drain();
      step();
      expect_("t1_int_m2", OBS_INT, 5'd0, 32'd0);
      drain();
      step();
      expect_("t1_int_stay", OBS_INT, 5'd0, 32'd0);
      drain();

      // 2. Priority between sources 5 and 17
      wr(INTC_EN0, 8'h20); wr(INTC_EN2, 8'h02); wr(INTC_TRIG0, 8'h20); wr(INTC_TRIG2, 8'h02);
      irq[5] = 1'b1; irq[17] = 1'b1; step(); irq[5] = 1'b0; irq[17] = 1'b0;
      expect_("t2_pend0", OBS_RD, INTC_PEND0, 32'h20);
      expect_("t2_pend2", OBS_RD, INTC_PEND2, 32'h02);
      drain();
      step();
      expect_("t2_int", OBS_INT, 5'd0, 32'd1);
      expect_("t2_code5", OBS_CODE, 5'd0, 32'd5);
      drain();
      wr(INTC_PEND0, 8'h20);
      expect_("t2_int_m1", OBS_INT, 5'd0, 32'd1);
      expect_("t2_code_m1", OBS_CODE, 5'd0, 32'd5);
      drain();
      step();
      expect_("t2_int_m2", OBS_INT, 5'd0, 32'd1);
      expect_("t2_code17", OBS_CODE, 5'd0, 32'd17);
      drain();
      wr(INTC_PEND2, 8'h02);
      step();
      expect_("t2_int_done", OBS_INT, 5'd0, 32'd0);
      expect_("t2_code_done", OBS_CODE, 5'd0, 32'd0);
      drain();

      // 3. Level source survives a clear while held high
      wr(INTC_TRIG0, 8'h00); wr(INTC_EN0, 8'h08);
      irq[3] = 1'b1; step(); step();
      expect_("t3_int", OBS_INT, 5'd0, 32'd1);
      expect_("t3_code", OBS_CODE, 5'd0, 32'd3);
      drain();
      wr(INTC_PEND0, 8'h08);
      expect_("t3_pend_held", OBS_RD, INTC_PEND0, 32'h08);
      drain();
      step();
      expect_("t3_int_held", OBS_INT, 5'd0, 32'd1);
      drain();
      irq[3] = 1'b0;
      wr(INTC_PEND0, 8'h08);
      expect_("t3_pend_clr", OBS_RD, INTC_PEND0, 32'h00);
      drain();
      step();
      expect_("t3_int_clr", OBS_INT, 5'd0, 32'd0);
      drain();

      // 4. Rising edge collides with W1C of the same bit
      wr(INTC_TRIG1, 8'h02);
      irq[9] = 1'b1;
      wr(INTC_PEND1, 8'h02);
      irq[9] = 1'b0;
      expect_("t4_pend_set_wins", OBS_RD, INTC_PEND1, 32'h02);
      drain();
      step();
      expect_("t4_pend_kept", OBS_RD, INTC_PEND1, 32'h02);
      expect_("t4_int_masked", OBS_INT, 5'd0, 32'd0);
      drain();
      wr(INTC_PEND1, 8'h02);
      expect_("t4_pend_clr", OBS_RD, INTC_PEND1, 32'h00);
      drain();

      // 5. Software interrupt, GIE gating
      wr(INTC_CTRL, 8'h00);
      wr(INTC_SWI, 8'h1F);
      expect_("t5_pend3", OBS_RD, INTC_PEND3, 32'h80);
      expect_("t5_swi_rd", OBS_RD, INTC_SWI, 32'h00);
      drain();
      step();
      expect_("t5_int_gated", OBS_INT, 5'd0, 32'd0);
      drain();
      wr(INTC_EN3, 8'h80); wr(INTC_CTRL, 8'h01);
      step();
      expect_("t5_int", OBS_INT, 5'd0, 32'd1);
      expect_("t5_code31", OBS_CODE, 5'd0, 32'd31);
      expect_("t5_cur", OBS_RD, INTC_CUR, 32'h9F);
      drain();
      wr(INTC_CTRL, 8'h00);
      expect_("t5_gie_off_m1", OBS_INT, 5'd0, 32'd1);
      drain();
      step();
      expect_("t5_gie_off_m2", OBS_INT, 5'd0, 32'd0);
      expect_("t5_pend_kept", OBS_RD, INTC_PEND3, 32'h80);
      drain();

      // 6. Reset during service
      wr(INTC_IVT2, 8'hAA);
      wr(INTC_CTRL, 8'h01);
      step();
      expect_("t6_int_pre", OBS_INT, 5'd0, 32'd1);
      expect_("t6_ivt_pre", OBS_IVT, 5'd0, 32'hAA0000);
      drain();
      rst = 1'b0; step(); rst = 1'b1;
      expect_("t6_int", OBS_INT, 5'd0, 32'd0);
      expect_("t6_code", OBS_CODE, 5'd0, 32'd0);
      expect_("t6_ivt", OBS_IVT, 5'd0, 32'd0);
      drain();
      for (int a = 0; a <= 17; a++) begin
         expect_("t6_rd", OBS_RD, 5'(a), 32'd0);
         drain();
      end
      wr(INTC_IVT0, 8'h12); wr(INTC_IVT1, 8'h34); wr(INTC_IVT2, 8'h56);
      expect_("t6_ivt_new", OBS_IVT, 5'd0, 32'h563412);
      drain();

      // Source-count boundary on the NSRC=20 copy
      wr(INTC_EN2, 8'hFF); wr(INTC_EN3, 8'hFF);
      expect_("n20_en2", OBS_RD20, INTC_EN2, 32'h0F);
      expect_("n20_en3", OBS_RD20, INTC_EN3, 32'h00);
      expect_("n32_en3", OBS_RD, INTC_EN3, 32'hFF);
      drain();
      wr(INTC_SWI, 8'd25); wr(INTC_SWI, 8'd19);
      expect_("n20_swi25", OBS_RD20, INTC_PEND3, 32'h00);
      expect_("n20_swi19", OBS_RD20, INTC_PEND2, 32'h08);
      expect_("n32_swi25", OBS_RD, INTC_PEND3, 32'h02);
      expect_("n32_swi19", OBS_RD, INTC_PEND2, 32'h08);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/intc_ls1u.md
Name: intc_ls1u

Overview:
- Memory-mapped priority interrupt controller that drives the LS1u+ core's `INT`, `INTCODE[5:0]` and `IVT_addr[23:0]` inputs.
- Collects up to 32 peripheral requests into a pending register, with per-source enable and per-source edge/level trigger, and asserts a registered interrupt with the lowest-index winner.
- Software programs and acknowledges it through an 8-bit register window decoded from `daddr`, `dwrite`, `ddata_o` and `ddata_i`.

Parameters:
- NSRC, 32, number of request inputs (1..32); bits at NSRC and above read 0 and cannot be set.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-low
- irq  in  NSRC  request lines; already synchronous to clk
- sel  in  1  register window selected (decoded from daddr by the bus fabric)
- addr  in  5  register offset, daddr[4:0]
- we  in  1  write strobe, from CPU dwrite
- wdata  in  8  write data, from CPU ddata_o
- rdata  out  8  read data; combinational from addr, 0 when sel=0
- int_o  out  1  to CPU INT
- intcode_o  out  6  to CPU INTCODE; bit 5 is always 0
- ivt_addr  out  24  to CPU IVT_addr

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: when rst=0 at a clk edge, PEND, EN, TRIG, CTRL, IVT, the irq_prev sample, int_o and intcode_o all clear to 0. Reset mid-operation drops all pending requests.
- Register map (writes take effect at the clk edge with sel&we):
  - 0x00-0x03 PEND bytes 0..3 (bits 7:0 .. 31:24): read; write-1-to-clear.
  - 0x04-0x07 EN: R/W.
  - 0x08-0x0B TRIG: R/W; 1 = rising edge, 0 = level.
  - 0x0C CTRL: bit0 = GIE, R/W; other bits read 0.
  - 0x0D CUR: read-only, {int_o, 2'b00, intcode_o[4:0]}.
  - 0x0E/0x0F/0x10 IVT low/mid/high: R/W, drive ivt_addr.
  - 0x11 SWI: a write sets PEND[wdata[4:0]] (ignored if index ≥ NSRC); reads 0.
  - Other offsets: read 0, writes ignored.
- Pending set rule, per bit each cycle:
  - set_i = TRIG_i ? (irq_i & ~irq_prev_i) : irq_i.
  - clr_i = W1C hit on bit i.
  - PEND_i <= set_i | swi_i | (PEND_i & ~clr_i). Set wins over a same-cycle clear, so no event is lost.
  - A level source held high therefore stays pending through a clear.
  - irq_prev <= irq every cycle.
- Delivery:
  - act = PEND & EN & {NSRC{GIE}}.
  - The priority encoder picks the lowest set index of act.
  - Registered: int_o <= |act; intcode_o <= {1'b0, index} (0 when act=0).
  - Latency: an irq edge at cycle N sets PEND at N+1 and int_o at N+2.
  - int_o and intcode_o always update together, so the CPU sees a consistent pair. The code may change while int_o stays high if a higher-priority source arrives.
- Acknowledge timing:
  - A W1C write sampled at cycle M clears PEND at M+1; int_o drops at M+2 if nothing else is active.
  - Because the CPU re-enters as soon as it executes RET with INT high, the ISR must issue the W1C store and then at least 2 further instructions before RET.
- Vector layout:
  - ivt_addr is passed through unmodified; the CPU adds intcode×4.
  - The IVT base must leave room for 32×4 instruction words.
- Clearing GIE or EN while int_o is high: int_o drops 1 cycle later; PEND is preserved.

Decomposition:
- Package intc_ls1u_pkg:
  - register offset localparams (INTC_PEND0..INTC_SWI);
  - NSRC_MAX = 32;
  - CTRL_GIE bit index.
- Sub-module intc_prio_enc:
  - combinational 32→5 lowest-index-first encoder with a valid output;
  - instantiated once;
  - verified standalone by exhaustive one-hot tests plus random tests.

Test Plan:
1. Edge source: TRIG=0x01, EN=0x01, GIE=1; pulse irq[0] for 1 cycle at N → PEND0=0x01 at N+1, int_o=1 and intcode_o=0 at N+2; write PEND0=0x01 → int_o=0 two cycles later.
2. Priority: irq[5] and irq[17] both pending and enabled → intcode_o=5; W1C bit 5 → intcode_o=17 two cycles later, int_o stays 1 throughout.
3. Level source: TRIG=0, irq[3] held high, W1C bit 3 → PEND stays 0x08 and int_o stays 1; drop irq[3], then W1C → int_o=0.
4. Set/clear collision: rising edge on irq[9] in the same cycle as a W1C of bit 9 → PEND1 reads 0x02 afterwards.
5. SWI and gating: GIE=0, write SWI=0x1F → PEND3=0x80, int_o=0; set EN3=0x80, GIE=1 → int_o=1, intcode_o=31, CUR reads 0x9F.
6. Reset mid-service: int_o=1, then rst=0 for one cycle → every register, int_o, intcode_o and ivt_addr read 0 on the next cycle; write IVT=0x12/0x34/0x56 → ivt_addr=0x563412.
